// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: shared command/state types and fixed TAP walk sequences for the JTAG master
package jtag_master_pkg;
    typedef enum logic [1:0] {
        TAP_RESET   = 2'b00,
        SHIFT_IR    = 2'b01,
        SHIFT_DR    = 2'b10,
        IDLE_CYCLES = 2'b11
    } cmd_type_e;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TLR,
        ST_IR_PRE,
        ST_DR_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RTI_RUN,
        ST_RESP
    } state_e;
    localparam int TLR_LEN    = 6;
    localparam int IR_PRE_LEN = 4;
    localparam int DR_PRE_LEN = 3;
    localparam int POST_LEN   = 2;
    localparam logic [TLR_LEN-1:0]    TLR_TMS    = 6'b011111;
    localparam logic [IR_PRE_LEN-1:0] IR_PRE_TMS = 4'b0011;
    localparam logic [DR_PRE_LEN-1:0] DR_PRE_TMS = 3'b001;
    localparam logic [POST_LEN-1:0]   POST_TMS   = 2'b01;
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides the system clock into a low-then-high TCK with rise/fall strobes
module jtag_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tck_o,
    output logic tck_rise_o,
    output logic tck_fall_o
);
    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d, wrap;
    assign wrap       = (cnt_q == CW'(TCK_DIV - 1));
    assign tck_rise_o = en_i & wrap & ~tck_q;
    assign tck_fall_o = en_i & wrap & tck_q;
    assign tck_o      = tck_q;
    // phase counter wraps every half period and toggles TCK; disabled means parked low
    always_comb begin
        cnt_d = (!en_i || wrap) ? '0 : cnt_q + 1'b1;
        tck_d = en_i ? (tck_q ^ wrap) : 1'b0;
    end
    // phase state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end
endmodule

// File: rtl/jtag_tap_master.sv
// jtag_tap_master: command-driven JTAG master walking a target TAP through reset, IR/DR scans and idle clocking
module jtag_tap_master
    import jtag_master_pkg::*;
#(
    parameter int IR_WIDTH     = 5,
    parameter int DR_MAX_WIDTH = 32,
    parameter int TCK_DIV      = 4
) (
    input  logic                               CLOCK,
    input  logic                               RESET,
    input  logic                               CMD_VALID,
    output logic                               CMD_READY,
    input  logic [1:0]                         CMD_TYPE,
    input  logic [$clog2(DR_MAX_WIDTH+1)-1:0]  CMD_LEN,
    input  logic [DR_MAX_WIDTH-1:0]            CMD_DATA,
    output logic                               RSP_VALID,
    input  logic                               RSP_READY,
    output logic [DR_MAX_WIDTH-1:0]            RSP_DATA,
    output logic                               BUSY,
    output logic                               TCK,
    output logic                               TMS,
    output logic                               TDI,
    input  logic                               TDO
);
    localparam int LW   = $clog2(DR_MAX_WIDTH + 1);
    localparam int MAXL = (DR_MAX_WIDTH > IR_WIDTH)
                        ? ((DR_MAX_WIDTH > TLR_LEN) ? DR_MAX_WIDTH : TLR_LEN)
                        : ((IR_WIDTH > TLR_LEN) ? IR_WIDTH : TLR_LEN);
    localparam int BW   = $clog2(MAXL + 1);

    state_e                  state_q, state_d;
    cmd_type_e               cmd;
    logic [BW-1:0]           bit_q, bit_d, len_q, len_d, lim;
    logic [DR_MAX_WIDTH-1:0] data_q, data_d, rsp_q, rsp_d;
    logic [7:0]              tms_seq;
    logic                    tms_q, tms_d, tdi_q, tdi_d, auto_q, auto_d;
    logic                    busy, last, tck_rise, tck_fall;

    assign cmd       = cmd_type_e'(CMD_TYPE);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_RESP);
    assign lim       = (state_q == ST_TLR)    ? BW'(TLR_LEN)    :
                       (state_q == ST_IR_PRE) ? BW'(IR_PRE_LEN) :
                       (state_q == ST_DR_PRE) ? BW'(DR_PRE_LEN) :
                       (state_q == ST_POST)   ? BW'(POST_LEN)   : len_q;
    assign last      = (bit_q == lim - 1'b1);
    assign CMD_READY = (state_q == ST_IDLE);
    assign RSP_VALID = (state_q == ST_RESP);
    assign BUSY      = busy;
    assign RSP_DATA  = rsp_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
        .clk_i      (CLOCK),
        .rst_i      (RESET),
        .en_i       (busy),
        .tck_o      (TCK),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall)
    );

    // command accept, per-bit sequencing on TCK edges, and the TMS/TDI value for the next bit
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        len_d   = len_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        auto_d  = auto_q;
        if (state_q == ST_IDLE && CMD_VALID) begin
            bit_d   = '0;
            auto_d  = 1'b0;
            rsp_d   = '0;
            data_d  = CMD_DATA;
            len_d   = (cmd == SHIFT_IR) ? BW'(IR_WIDTH) :
                      (CMD_LEN > LW'(DR_MAX_WIDTH)) ? BW'(DR_MAX_WIDTH) : BW'(CMD_LEN);
            state_d = (cmd == TAP_RESET) ? ST_TLR    :
                      (cmd == SHIFT_IR)  ? ST_IR_PRE :
                      (CMD_LEN == '0)    ? ST_RESP   :
                      (cmd == SHIFT_DR)  ? ST_DR_PRE : ST_RTI_RUN;
        end else if (state_q == ST_RESP) begin
            state_d = RSP_READY ? ST_IDLE : ST_RESP;
        end else if (tck_rise && state_q == ST_SHIFT) begin
            rsp_d = rsp_q | ({{(DR_MAX_WIDTH-1){1'b0}}, TDO} << bit_q);
        end else if (tck_fall) begin
            data_d  = (state_q == ST_SHIFT) ? (data_q >> 1) : data_q;
            bit_d   = last ? '0 : bit_q + 1'b1;
            state_d = !last                                          ? state_q :
                      (state_q == ST_TLR)                            ? (auto_q ? ST_IDLE : ST_RESP) :
                      (state_q == ST_IR_PRE || state_q == ST_DR_PRE) ? ST_SHIFT :
                      (state_q == ST_SHIFT)                          ? ST_POST  : ST_RESP;
        end
        tms_seq = ((state_d == ST_TLR)    ? 8'(TLR_TMS)    :
                   (state_d == ST_IR_PRE) ? 8'(IR_PRE_TMS) :
                   (state_d == ST_DR_PRE) ? 8'(DR_PRE_TMS) :
                   (state_d == ST_POST)   ? 8'(POST_TMS)   : 8'h00) >> bit_d;
        tms_d   = (state_d == ST_SHIFT) ? (bit_d == len_d - 1'b1) : tms_seq[0];
        tdi_d   = (state_d == ST_SHIFT) & data_d[0];
    end

    // state registers; reset parks in TLR so the automatic TAP reset runs on release
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_TLR;
            bit_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            auto_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            auto_q  <= auto_d;
        end
    end
endmodule

// File: tb/tb_jtag_tap_master.sv
// tb_jtag_tap_master: directed scoreboard bench driving the master against a behavioural target TAP
module tb_jtag_tap_master;
    logic        CLOCK = 1'b0, RESET = 1'b1, CMD_VALID = 1'b0, RSP_READY = 1'b0, TDO = 1'b0;
    logic [1:0]  CMD_TYPE = 2'b00;
    logic [5:0]  CMD_LEN = '0;
    logic [31:0] CMD_DATA = '0;
    logic        CMD_READY, RSP_VALID, BUSY, TCK, TMS, TDI;
    logic [31:0] RSP_DATA;
    int          vectors = 0, errs = 0;
    logic [31:0] exp_q[$];

    always #5 CLOCK = ~CLOCK;

    jtag_tap_master #(.IR_WIDTH(5), .DR_MAX_WIDTH(32), .TCK_DIV(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .BUSY(BUSY),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UPD_DR,
        T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UPD_IR
    } tap_e;
    tap_e        tap = T_TLR;
    logic [4:0]  opcode = 5'b11111, ish = '0;
    logic [31:0] ureg = 32'hCAFE0001, dsh = '0;
    int          tck_cnt = 0;
    logic        tms_log [0:1023];
    logic        tdi_log [0:1023];

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            T_TLR:    return m ? T_TLR    : T_RTI;
            T_RTI:    return m ? T_SEL_DR : T_RTI;
            T_SEL_DR: return m ? T_SEL_IR : T_CAP_DR;
            T_CAP_DR: return m ? T_EX1_DR : T_SH_DR;
            T_SH_DR:  return m ? T_EX1_DR : T_SH_DR;
            T_EX1_DR: return m ? T_UPD_DR : T_PA_DR;
            T_PA_DR:  return m ? T_EX2_DR : T_PA_DR;
            T_EX2_DR: return m ? T_UPD_DR : T_SH_DR;
            T_UPD_DR: return m ? T_SEL_DR : T_RTI;
            T_SEL_IR: return m ? T_TLR    : T_CAP_IR;
            T_CAP_IR: return m ? T_EX1_IR : T_SH_IR;
            T_SH_IR:  return m ? T_EX1_IR : T_SH_IR;
            T_EX1_IR: return m ? T_UPD_IR : T_PA_IR;
            T_PA_IR:  return m ? T_EX2_IR : T_PA_IR;
            T_EX2_IR: return m ? T_UPD_IR : T_SH_IR;
            default:  return m ? T_SEL_DR : T_RTI;
        endcase
    endfunction

    // target TAP: state walk and register actions on TCK rise, plus a log of TMS/TDI per pulse
    always @(posedge TCK) begin
        tms_log[tck_cnt % 1024] <= TMS;
        tdi_log[tck_cnt % 1024] <= TDI;
        tck_cnt <= tck_cnt + 1;
        case (tap)
            T_TLR:    opcode <= 5'b11111;
            T_CAP_IR: ish <= 5'b00001;
            T_SH_IR:  ish <= {TDI, ish[4:1]};
            T_UPD_IR: opcode <= ish;
            T_CAP_DR: dsh <= (opcode == 5'b11111) ? 32'h0 : ureg;
            T_SH_DR:  dsh <= (opcode == 5'b11111) ? {31'h0, TDI} : {TDI, dsh[31:1]};
            T_UPD_DR: if (opcode != 5'b11111) ureg <= dsh;
            default: ;
        endcase
        tap <= tap_next(tap, TMS);
    end

    // target drives TDO on TCK fall
    always @(negedge TCK) TDO <= (tap == T_SH_DR) ? dsh[0] : (tap == T_SH_IR) ? ish[0] : 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dr_tms(input int n);
        return 64'h1 | (64'h1 << (n + 2)) | (64'h1 << (n + 3));
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (CMD_READY !== 1'b1 && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] t, input logic [5:0] len,
                       input logic [31:0] d, input logic [31:0] er, input int ep,
                       input logic [63:0] etms, input logic [63:0] etdi, input int hold,
                       output int cyc);
        int          n, base, c0;
        logic [63:0] vt, vd;
        logic [31:0] e;
        wait_ready(n);
        chk({tag, "_ready"}, CMD_READY, 1'b1);
        CMD_TYPE  = t;
        CMD_LEN   = len;
        CMD_DATA  = d;
        CMD_VALID = 1'b1;
        base      = tck_cnt;
        exp_q.push_back(er);
        @(negedge CLOCK);
        CMD_VALID = 1'b0;
        cyc = 1;
        while (RSP_VALID !== 1'b1 && cyc < 2000) begin
            @(negedge CLOCK);
            cyc++;
        end
        chk({tag, "_rsp_valid"}, RSP_VALID, 1'b1);
        chk({tag, "_pulses"}, 64'(tck_cnt - base), 64'(ep));
        vt = '0;
        vd = '0;
        for (int i = 0; i < ep && i < 64; i++) begin
            vt[i] = tms_log[(base + i) % 1024];
            vd[i] = tdi_log[(base + i) % 1024];
        end
        chk({tag, "_tms"}, vt, etms);
        chk({tag, "_tdi"}, vd, etdi);
        c0 = tck_cnt;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLOCK);
            chk({tag, "_hold_valid"}, RSP_VALID, 1'b1);
            chk({tag, "_hold_data"}, RSP_DATA, er);
            chk({tag, "_hold_ready"}, CMD_READY, 1'b0);
        end
        if (hold > 0) chk({tag, "_hold_tck"}, 64'(tck_cnt - c0), 64'd0);
        e = exp_q.pop_front();
        chk({tag, "_data"}, RSP_DATA, e);
        RSP_READY = 1'b1;
        @(negedge CLOCK);
        RSP_READY = 1'b0;
        chk({tag, "_rsp_clear"}, RSP_VALID, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tck"}, TCK, 1'b0);
        chk({tag, "_tms"}, TMS, 1'b1);
        chk({tag, "_tdi"}, TDI, 1'b0);
        chk({tag, "_cmd_ready"}, CMD_READY, 1'b0);
        chk({tag, "_rsp_valid"}, RSP_VALID, 1'b0);
        chk({tag, "_rsp_data"}, RSP_DATA, 32'h0);
        chk({tag, "_busy"}, BUSY, 1'b1);
    endtask

    task automatic release_and_check(input string tag);
        int n, base;
        base  = tck_cnt;
        RESET = 1'b0;
        wait_ready(n);
        chk({tag, "_ready_cycles"}, 64'(n), 64'd24);
        chk({tag, "_pulses"}, 64'(tck_cnt - base), 64'd6);
        for (int i = 0; i < 6; i++) chk({tag, "_tms_bit"}, tms_log[(base + i) % 1024], (i < 5) ? 1'b1 : 1'b0);
        chk({tag, "_busy_idle"}, BUSY, 1'b0);
        chk({tag, "_tap_rti"}, tap, T_RTI);
    endtask

    initial begin
        int cyc, n, base;
        repeat (3) @(negedge CLOCK);
        check_reset_values("rst");
        release_and_check("auto_tlr");

        run("ir_00110", 2'b01, 6'd0, 32'h00000006, 32'h1, 11, 64'h303, 64'h60, 0, cyc);
        chk("ir_opcode", opcode, 5'b00110);
        run("dr_user1", 2'b10, 6'd32, 32'h13579BDF, 32'hCAFE0001, 37, dr_tms(32), 64'h13579BDF << 3, 0, cyc);
        run("dr_user2", 2'b10, 6'd32, 32'h2468ACE0, 32'h13579BDF, 37, dr_tms(32), 64'h2468ACE0 << 3, 0, cyc);
        run("tap_reset", 2'b00, 6'd0, 32'hFFFFFFFF, 32'h0, 6, 64'h1F, 64'h0, 0, cyc);
        chk("tlr_opcode", opcode, 5'b11111);
        run("ir_bypass", 2'b01, 6'd0, 32'h0000001F, 32'h1, 11, 64'h303, 64'h1F0, 0, cyc);
        run("dr_deadbeef", 2'b10, 6'd32, 32'hDEADBEEF, 32'hBD5B7DDE, 37, dr_tms(32), 64'hDEADBEEF << 3, 10, cyc);
        run("dr_len8", 2'b10, 6'd8, 32'hFFFFFFA5, 32'h0000004A, 13, dr_tms(8), 64'hA5 << 3, 0, cyc);
        run("dr_len0", 2'b10, 6'd0, 32'h12345678, 32'h0, 0, 64'h0, 64'h0, 0, cyc);
        chk("dr_len0_latency", 64'(cyc), 64'd1);
        run("dr_len40", 2'b10, 6'd40, 32'h80000001, 32'h00000002, 37, dr_tms(32), 64'h80000001 << 3, 0, cyc);
        run("idle5", 2'b11, 6'd5, 32'hFFFFFFFF, 32'h0, 5, 64'h0, 64'h0, 0, cyc);
        run("idle0", 2'b11, 6'd0, 32'h0, 32'h0, 0, 64'h0, 64'h0, 0, cyc);
        chk("idle0_latency", 64'(cyc), 64'd1);

        run("ir_pre_reset", 2'b01, 6'd0, 32'h00000006, 32'h1, 11, 64'h303, 64'h60, 0, cyc);
        chk("pre_reset_opcode", opcode, 5'b00110);
        wait_ready(n);
        CMD_TYPE  = 2'b10;
        CMD_LEN   = 6'd32;
        CMD_DATA  = 32'h0F0F0F0F;
        CMD_VALID = 1'b1;
        base      = tck_cnt;
        @(negedge CLOCK);
        CMD_VALID = 1'b0;
        n = 0;
        while ((tck_cnt - base) < 13 && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
        chk("midrst_reached_bit10", 64'(tck_cnt - base), 64'd13);
        RESET = 1'b1;
        @(negedge CLOCK);
        check_reset_values("midrst");
        @(negedge CLOCK);
        release_and_check("midrst_tlr");
        chk("midrst_opcode", opcode, 5'b11111);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/jtag_tap_master.md
Name: jtag_tap_master

Overview:
JTAG master that drives TCK/TMS/TDI and samples TDO, walking an IEEE 1149.1 target TAP controller through IR and DR scans. It is the initiator end for the chip's TAP, instruction register and data registers. It is used in the DAQ/test-bench side to configure the chip. A simple command/response handshake on the CLOCK domain issues TAP reset, IR scan, DR scan and idle-clocking operations.

Parameters:
IR_WIDTH, 5, target instruction-register length in bits
DR_MAX_WIDTH, 32, maximum DR scan length in bits
TCK_DIV, 4, TCK half-period in CLOCK cycles (>=1)

Ports:
CLOCK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
CMD_VALID  in  1  command request
CMD_READY  out  1  master can accept a command
CMD_TYPE  in  2  00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE_CYCLES
CMD_LEN  in  $clog2(DR_MAX_WIDTH+1)  DR bit count, or idle TCK count
CMD_DATA  in  DR_MAX_WIDTH  scan-in data, LSB shifted first
RSP_VALID  out  1  response available
RSP_READY  in  1  response consumed
RSP_DATA  out  DR_MAX_WIDTH  captured TDO bits, right-justified, LSB first-received
BUSY  out  1  TAP sequence in progress
TCK  out  1  JTAG clock
TMS  out  1  JTAG mode select
TDI  out  1  JTAG serial data to target
TDO  in  1  JTAG serial data from target

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0, BUSY=1.
- After RESET deasserts, the master automatically runs the TAP_RESET sequence. CMD_READY first rises after that sequence completes.
- TCK bit-cycle: low phase of TCK_DIV CLOCK cycles, then high phase of TCK_DIV CLOCK cycles. TCK idles low.
- TMS and TDI change only in the CLOCK cycle where TCK goes 1->0, or at the start of the first low phase.
- TDO is registered in the CLOCK cycle where TCK is driven 0->1. The captured value is the TDO value present before that edge.
- All sequences start from and end in Run-Test/Idle (RTI). The master keeps no other resting state.
- TAP_RESET: 6 TCK cycles with TMS = 1,1,1,1,1,0.
- SHIFT_IR: TMS = 1,1,0,0, then IR_WIDTH bits with TMS=0 except TMS=1 on the last bit, then 1,0. Total IR_WIDTH+6 TCK cycles. CMD_LEN is ignored.
- SHIFT_DR: TMS = 1,0,0, then N bits with TMS=1 on the last bit, then 1,0. Total N+5 TCK cycles.
- IDLE_CYCLES: CMD_LEN TCK cycles with TMS=0.
- TDI during shift carries CMD_DATA[i] for bit i. Outside shift, TDI=0.
- RSP_DATA[i] = TDO captured on shift bit i. Bits at positions >= N are 0. For TAP_RESET and IDLE_CYCLES, RSP_DATA=0.
- Length boundaries:
  - N = CMD_LEN for DR; CMD_LEN > DR_MAX_WIDTH is clamped to DR_MAX_WIDTH.
  - CMD_LEN=0 on SHIFT_DR or IDLE_CYCLES produces no TCK edge. RSP_VALID asserts in the next CLOCK cycle.
- Handshake:
  - A command is accepted on CMD_VALID & CMD_READY.
  - CMD_READY=1 only when FSM=IDLE and RSP_VALID=0.
  - RSP_VALID rises one CLOCK cycle after the final TCK falling edge. It holds, with RSP_DATA stable, until RSP_READY=1.
  - RSP_VALID & RSP_READY clears RSP_VALID. CMD_READY may rise in the same cycle.
- FSM states and transitions:
  - IDLE -> (TLR | IR_PRE | DR_PRE | RTI_RUN) on accept.
  - IR_PRE / DR_PRE -> SHIFT.
  - SHIFT -> POST.
  - POST -> RESP.
  - TLR / RTI_RUN -> RESP.
  - RESP -> IDLE on RSP_READY.
- BUSY=1 in every state except IDLE and RESP.
- RESET mid-operation: outputs return to their reset values on the next CLOCK edge, any pending response is discarded, and the auto TAP_RESET sequence reruns.

Decomposition:
- Package jtag_master_pkg holds:
  - cmd_type_e enum (TAP_RESET, SHIFT_IR, SHIFT_DR, IDLE_CYCLES);
  - master state enum;
  - pre/post TMS sequence constants and lengths (TLR=6, IR pre=4, DR pre=3, post=2).
- IR opcodes come from the existing JTAG IR codes package.
- Sub-module jtag_tck_gen: TCK_DIV counter producing TCK plus single-cycle tck_rise and tck_fall strobes. Its enable comes from the master FSM.

Test Plan:
- RESET high 3 cycles, then low, TCK_DIV=2 -> 6 TCK pulses with TMS 1,1,1,1,1,0; CMD_READY rises 24 CLOCK cycles after reset release.
- SHIFT_IR, CMD_DATA=5'b00110, against the IR model -> 11 TCK pulses, TMS 1,1,0,0,0,0,0,0,1,1,0; TDI LSB first 0,1,1,0,0; RSP_DATA[1:0]=2'b01; target OPCODE=5'b00110 after Update-IR.
- SHIFT_DR, LEN=32, data 0xDEADBEEF, target in BYPASS -> 37 TCK pulses; RSP_DATA=0xBD5B7DDE.
- SHIFT_DR LEN=0 -> no TCK edge, RSP_VALID one cycle after accept, RSP_DATA=0. SHIFT_DR LEN=40 -> 37 TCK pulses (clamped to 32 bits).
- RSP_READY held low 10 cycles after response -> RSP_VALID and RSP_DATA stable, CMD_READY=0 throughout, no TCK activity.
- RESET asserted after 10 DR shift bits -> next cycle TCK=0, TMS=1, RSP_VALID=0, BUSY=1; the TAP_RESET sequence reruns and the target reads BYPASS opcode.
